// File: rtl/serial_paralelo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_paralelo                                            |
// | Description : MSB-first serial-to-parallel receiver with comma alignment |
// |               and lock detection.                                        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module serial_paralelo #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [3:0] C_LOCK_CNT = 4'(COMMA_COUNT);

    logic [1:0] r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_bc_cnt;
    logic [7:0] r_data_out;
    logic       r_valid;
    logic       r_active;
    logic       r_comma_det;

    logic [1:0] w_state;
    logic [2:0] w_bit_cnt;
    logic [3:0] w_bc_cnt;
    logic [3:0] w_bc_inc;
    logic [7:0] w_data_out;
    logic       w_valid;
    logic       w_active;
    logic       w_comma_det;
    logic [7:0] w_nxt;
    logic       w_is_comma;
    logic       w_boundary;

    // Candidate byte includes the bit arriving this cycle
    assign w_nxt      = {r_sr[6:0], data_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_bc_inc   = r_bc_cnt + 4'd1;

    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_bc_cnt    = r_bc_cnt;
        w_data_out  = r_data_out;
        w_valid     = 1'b0;
        w_active    = r_active;
        w_comma_det = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_is_comma) begin
                    w_bit_cnt = 3'd0;
                    w_bc_cnt  = 4'd1;
                    if (C_LOCK_CNT == 4'd1) begin
                        w_state  = ST_LOCKED;
                        w_active = 1'b1;
                    end else begin
                        w_state  = ST_LOCKING;
                    end
                end
            end
            ST_LOCKING: begin
                w_bit_cnt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_det = 1'b1;
                        w_bc_cnt    = w_bc_inc;
                        if (w_bc_inc == C_LOCK_CNT) begin
                            w_state  = ST_LOCKED;
                            w_active = 1'b1;
                        end
                    end else begin
                        w_state  = ST_HUNT;
                        w_bc_cnt = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                w_bit_cnt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_det = 1'b1;
                    end else begin
                        w_data_out = w_nxt;
                        w_valid    = 1'b1;
                    end
                end
            end
            default: begin
                w_state = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk32_f) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_bc_cnt    <= 4'd0;
            r_data_out  <= 8'h00;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_comma_det <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sr        <= w_nxt;
            r_bit_cnt   <= w_bit_cnt;
            r_bc_cnt    <= w_bc_cnt;
            r_data_out  <= w_data_out;
            r_valid     <= w_valid;
            r_active    <= w_active;
            r_comma_det <= w_comma_det;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign active    = r_active;
    assign comma_det = r_comma_det;

endmodule
`default_nettype wire
